sobel_out_packer: RTL

- Parametrised successor to the Sobel output stage. Collects normalised pixel beats for ROWS concurrently processed image rows, packs each row into WORD_W-bit SRAM words and writes them one row at a time.
- Row r of a word set goes to base + r*ROW_WORDS. The base advances by column and skips the rows already covered by the set.
- Sits between the normaliser and the SRAM write port.
- Unlike the fixed 2-row/4-beat stage, it adds a ready/valid input, SRAM back-pressure, double buffering and frame-end wrap.

---
 rtl/sobel_out_packer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sobel_out_packer.sv
// Sobel output packer: gathers ROWS x PIX_PER_ROW pixel beats into WORD_W words per row and
// writes them row by row to SRAM with back-pressure. Optional flush input under SOBEL_OUT_FLUSH_EN.
module sobel_out_packer #(
  parameter int          PIX_W       = 8,
  parameter int          PIX_PER_ROW = 2,
  parameter int          ROWS        = 2,
  parameter int          WORD_W      = 64,
  parameter int          ADDR_W      = 20,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned END_ADDR    = 524287,
  parameter int unsigned ROW_WORDS   = 256
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ROWS*PIX_PER_ROW*PIX_W-1:0]   in_data,
  input  logic                                wr_ready,
`ifdef SOBEL_OUT_FLUSH_EN
  input  logic                                flush,
`endif
  output logic                                we,
  output logic [ADDR_W-1:0]                   wraddr,
  output logic [WORD_W-1:0]                   out_data,
  output logic                                frame_done
);

  localparam int BEAT_W = PIX_W * PIX_PER_ROW;
  localparam int BPW    = WORD_W / BEAT_W;
  localparam int BCW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int RIW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RW_LOG = $clog2(ROW_WORDS);

  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] RW_MASK   = ADDR_W'(ROW_WORDS - 1);
  localparam logic [ADDR_W-1:0] SPAN_A    = ADDR_W'((ROWS - 1) * ROW_WORDS);
  localparam logic [ADDR_W-1:0] LIMIT_A   = ADDR_W'(END_ADDR - (ROWS - 1) * ROW_WORDS);
  localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BPW - 1);
  localparam logic [RIW-1:0]    LAST_ROW  = RIW'(ROWS - 1);

  typedef enum logic {IDLE, WR} state_t;

  state_t            state;
  logic [RIW-1:0]    row;
  logic [BCW-1:0]    beat_cnt;
  logic [ADDR_W-1:0] base;
  logic              hold_valid;
  logic [WORD_W-1:0] collect     [ROWS];
  logic [WORD_W-1:0] collect_nxt [ROWS];
  logic [WORD_W-1:0] hold        [ROWS];

  logic              accept, drain_last, xfer, wrap;
  logic              flush_req, flush_xfer;
  logic [ADDR_W-1:0] nb;
  logic [RIW-1:0]    row_nxt;

  function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [RIW-1:0]    r);
    return b + (ADDR_W'(r) << RW_LOG);
  endfunction

  // At the end of an image row the next set starts below the rows this set already covered.
  function automatic logic [ADDR_W-1:0] step_base(input logic [ADDR_W-1:0] b);
    if ((b & RW_MASK) == RW_MASK) return b + SPAN_A + ADDR_W'(1);
    return b + ADDR_W'(1);
  endfunction

  assign drain_last = (state == WR) && (row == LAST_ROW) && wr_ready;
  assign row_nxt    = row + 1'b1;
  assign nb         = step_base(base);
  assign wrap       = nb > LIMIT_A;

`ifdef SOBEL_OUT_FLUSH_EN
  logic flush_pend;
  assign flush_req  = flush_pend || (flush && (beat_cnt != '0));
  assign flush_xfer = flush_req && (!hold_valid || drain_last);
`else
  assign flush_req  = 1'b0;
  assign flush_xfer = 1'b0;
`endif

  assign in_ready = !((beat_cnt == LAST_BEAT) && hold_valid && !drain_last) && !flush_req;
  assign accept   = in_valid && in_ready;
  assign xfer     = (accept && (beat_cnt == LAST_BEAT)) || flush_xfer;

  // First beat of a set occupies the most significant slot of each row word.
  always_comb begin
    collect_nxt = collect;
    if (accept) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int p = 0; p < PIX_PER_ROW; p++) begin
          collect_nxt[r][(BPW-1-int'(beat_cnt))*BEAT_W + p*PIX_W +: PIX_W] =
            in_data[(r*PIX_PER_ROW+p)*PIX_W +: PIX_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      beat_cnt   <= '0;
      base       <= START_A;
      hold_valid <= 1'b0;
      we         <= 1'b0;
      wraddr     <= START_A;
      out_data   <= '0;
      frame_done <= 1'b0;
      collect    <= '{default: '0};
`ifdef SOBEL_OUT_FLUSH_EN
      flush_pend <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef SOBEL_OUT_FLUSH_EN
      if (flush_xfer)                          flush_pend <= 1'b0;
      else if (flush && (beat_cnt != '0))      flush_pend <= 1'b1;
`endif
      // Collection: cleared after every transfer so a flushed set is zero-filled.
      if (xfer) begin
        beat_cnt <= '0;
        collect  <= '{default: '0};
        hold     <= collect_nxt;
      end else begin
        collect  <= collect_nxt;
        if (accept) beat_cnt <= beat_cnt + 1'b1;
      end

      if (xfer)            hold_valid <= 1'b1;
      else if (drain_last) hold_valid <= 1'b0;

      // Drain: one row per accepted write; outputs hold while the SRAM stalls.
      case (state)
        IDLE: begin
          if (hold_valid) begin
            state    <= WR;
            row      <= '0;
            we       <= 1'b1;
            wraddr   <= base;
            out_data <= hold[0];
          end
        end
        WR: begin
          if (wr_ready) begin
            if (row != LAST_ROW) begin
              row      <= row_nxt;
              wraddr   <= row_addr(base, row_nxt);
              out_data <= hold[row_nxt];
            end else begin
              base       <= wrap ? START_A : nb;
              frame_done <= wrap;
              if (xfer) begin
                row      <= '0;
                wraddr   <= wrap ? START_A : nb;
                out_data <= collect_nxt[0];
              end else begin
                state <= IDLE;
                we    <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
